// File: rtl/ram_arbiter_if.sv
// Bus bundle between the requesters/RAM environment and the RAM arbiter.
// master: the requesters plus the RAM, which drive requests and read data.
// slave:  the arbiter, which drives grants and the RAM control pins.
interface ram_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 16,
  parameter int unsigned DW   = 4
);
  // Requester side
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*3-1:0]  blen;
  logic [NREQ*AW-1:0] addr_in;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic [NREQ-1:0]    rvalid;
  logic               busy;
  // RAM side
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_we;
  logic               mem_re;
  logic [DW-1:0]      mem_rdata;

  modport master (
    output req, we, blen, addr_in, wdata, mem_rdata,
    input  gnt, ack, rdata, rvalid, busy, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    input  req, we, blen, addr_in, wdata, mem_rdata,
    output gnt, ack, rdata, rvalid, busy, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one nibble-wide RAM between NREQ requesters.
// Each grant covers one burst of 1..8 beats at consecutive (wrapping) addresses.
// Beat strobes are decoded from the FSM state and the owner's live request so
// that dropping req aborts the burst in the same cycle without issuing a beat.
module ram_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 16,
  parameter int unsigned DW   = 4
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StDrain
  } state_e;

  state_e        state_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] last_q;
  logic [AW-1:0] base_q;
  logic          we_q;
  logic [2:0]    len_q;
  logic [2:0]    beat_q;
  logic          rv_q;     // a read beat was issued in the previous cycle

  logic          pick_vld;
  logic [OW-1:0] pick;
  logic [OW-1:0] cand;
  logic          own_req;
  logic          issue;

  function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign own_req = bus.req[owner_q];
  assign issue   = (state_q == StXfer) && own_req && !rst;

  // Round-robin search starting just after the last owner.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = OW'((32'(last_q) + k) % NREQ);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // Burst FSM and latched burst parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
      base_q  <= '0;
      we_q    <= 1'b0;
      len_q   <= '0;
      beat_q  <= '0;
      rv_q    <= 1'b0;
    end else begin
      rv_q <= issue && !we_q;
      case (state_q)
        StIdle: begin
          if (pick_vld) begin
            owner_q <= pick;
            last_q  <= pick;
            base_q  <= bus.addr_in[32'(pick)*AW +: AW];
            we_q    <= bus.we[pick];
            len_q   <= bus.blen[32'(pick)*3 +: 3];
            beat_q  <= '0;
            state_q <= StXfer;
          end
        end
        StXfer: begin
          if (!own_req) begin
            // Aborted read with beats already issued still passes through
            // DRAIN so the turnaround after any read burst looks the same.
            state_q <= (!we_q && beat_q != 3'd0) ? StDrain : StIdle;
          end else if (beat_q == len_q) begin
            state_q <= we_q ? StIdle : StDrain;
          end else begin
            beat_q <= beat_q + 3'd1;
          end
        end
        StDrain: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Grant, beat strobes and read-data return decoded from the current state.
  always_comb begin
    bus.gnt       = '0;
    bus.ack       = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.rvalid    = '0;
    bus.rdata     = '0;
    bus.busy      = (state_q != StIdle) && !rst;
    if (issue) begin
      bus.gnt      = onehot(owner_q);
      bus.ack      = onehot(owner_q);
      bus.mem_addr = base_q + AW'(beat_q);
      if (we_q) begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = bus.wdata[32'(owner_q)*DW +: DW];
      end else begin
        bus.mem_re = 1'b1;
      end
    end
    if (rv_q && !rst) begin
      bus.rvalid = onehot(owner_q);
      bus.rdata  = bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a per-cycle vector table for wrap write,
// read pipeline and reset mid-burst, plus sequences for round-robin order,
// abort and fairness.
module tb_ram_arbiter;

  logic clk;
  logic rst;

  ram_arbiter_if #(.NREQ(4), .AW(16), .DW(4)) bus ();

  ram_arbiter #(.NREQ(4), .AW(16), .DW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read data is a fixed function of the address (addr[3:0] + A),
  // so 0010, 0011, 0012 return A, B, C. Writes are observed on the pins only.
  always_ff @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= bus.mem_addr[3:0] + 4'hA;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [11:0] blen;
    logic [63:0] addr;
    logic [15:0] wdata;
    logic [38:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  localparam logic [38:0] Z = 39'h0;

  function automatic logic [38:0] o(input logic [3:0] g, input logic [3:0] a,
                                    input logic mwe, input logic mre,
                                    input logic [15:0] ma, input logic [3:0] mwd,
                                    input logic [3:0] rv, input logic [3:0] rd,
                                    input logic bz);
    return {g, a, mwe, mre, ma, mwd, rv, rd, bz};
  endfunction

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] w,
                     input logic [11:0] bl, input logic [63:0] ad,
                     input logic [15:0] wd, input logic [38:0] e);
    vec_t v;
    v.rst = r; v.req = rq; v.we = w; v.blen = bl; v.addr = ad; v.wdata = wd; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Address/write-data/read-data fields are masked when their strobe is low.
  function automatic logic [38:0] observed();
    return {bus.gnt, bus.ack, bus.mem_we, bus.mem_re,
            (bus.mem_we | bus.mem_re) ? bus.mem_addr : 16'h0,
            bus.mem_we ? bus.mem_wdata : 4'h0,
            bus.rvalid,
            (bus.rvalid != 4'h0) ? bus.rdata : 4'h0,
            bus.busy};
  endfunction

  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] w,
                       input logic [11:0] bl, input logic [63:0] ad, input logic [15:0] wd);
    rst = r; bus.req = rq; bus.we = w; bus.blen = bl; bus.addr_in = ad; bus.wdata = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 4'h0, 4'h0, 12'h0, 64'h0, 16'h0);
    step();
    rst = 1'b0;
  endtask

  logic [3:0] exp_rr [10];
  logic [3:0] starts [$];
  logic [3:0] prev_ack;
  int         bad;

  initial begin
    drive(1'b1, 4'h0, 4'h0, 12'h0, 64'h0, 16'h0);

    // Reset, then T1: requester 2 writes 4 beats from FFFE, wrapping to 0000.
    add(1'b1, 4'h0, 4'h0, 12'h0, 64'h0, 16'h0, Z);
    add(1'b0, 4'h0, 4'h0, 12'h0, 64'h0, 16'h0, Z);
    add(1'b0, 4'b0100, 4'b0100, 12'h0C0, 64'h0000_FFFE_0000_0000, 16'h0100, Z);
    add(1'b0, 4'b0100, 4'b0100, 12'h0C0, 64'h0000_FFFE_0000_0000, 16'h0100,
        o(4'b0100, 4'b0100, 1'b1, 1'b0, 16'hFFFE, 4'h1, 4'h0, 4'h0, 1'b1));
    add(1'b0, 4'b0100, 4'b0100, 12'h0C0, 64'h0000_FFFE_0000_0000, 16'h0200,
        o(4'b0100, 4'b0100, 1'b1, 1'b0, 16'hFFFF, 4'h2, 4'h0, 4'h0, 1'b1));
    add(1'b0, 4'b0100, 4'b0100, 12'h0C0, 64'h0000_FFFE_0000_0000, 16'h0300,
        o(4'b0100, 4'b0100, 1'b1, 1'b0, 16'h0000, 4'h3, 4'h0, 4'h0, 1'b1));
    add(1'b0, 4'b0100, 4'b0100, 12'h0C0, 64'h0000_FFFE_0000_0000, 16'h0400,
        o(4'b0100, 4'b0100, 1'b1, 1'b0, 16'h0001, 4'h4, 4'h0, 4'h0, 1'b1));
    add(1'b0, 4'h0, 4'h0, 12'h0, 64'h0, 16'h0, Z);
    // T3: requester 1 reads 3 beats at 0010; data returns one cycle later.
    add(1'b0, 4'b0010, 4'h0, 12'h010, 64'h0000_0000_0010_0000, 16'h0, Z);
    add(1'b0, 4'b0010, 4'h0, 12'h010, 64'h0000_0000_0010_0000, 16'h0,
        o(4'b0010, 4'b0010, 1'b0, 1'b1, 16'h0010, 4'h0, 4'h0, 4'h0, 1'b1));
    add(1'b0, 4'b0010, 4'h0, 12'h010, 64'h0000_0000_0010_0000, 16'h0,
        o(4'b0010, 4'b0010, 1'b0, 1'b1, 16'h0011, 4'h0, 4'b0010, 4'hA, 1'b1));
    add(1'b0, 4'b0010, 4'h0, 12'h010, 64'h0000_0000_0010_0000, 16'h0,
        o(4'b0010, 4'b0010, 1'b0, 1'b1, 16'h0012, 4'h0, 4'b0010, 4'hB, 1'b1));
    add(1'b0, 4'h0, 4'h0, 12'h010, 64'h0000_0000_0010_0000, 16'h0,
        o(4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000, 4'h0, 4'b0010, 4'hC, 1'b1));
    add(1'b0, 4'h0, 4'h0, 12'h0, 64'h0, 16'h0, Z);
    // T5: requester 2 read burst, reset on its second beat; then 0 beats 1.
    add(1'b0, 4'b0100, 4'h0, 12'h0C0, 64'h0000_0010_0000_0000, 16'h0, Z);
    add(1'b0, 4'b0100, 4'h0, 12'h0C0, 64'h0000_0010_0000_0000, 16'h0,
        o(4'b0100, 4'b0100, 1'b0, 1'b1, 16'h0010, 4'h0, 4'h0, 4'h0, 1'b1));
    add(1'b1, 4'b0100, 4'h0, 12'h0C0, 64'h0000_0010_0000_0000, 16'h0, Z);
    add(1'b0, 4'b0011, 4'b0011, 12'h0, 64'h0000_0000_ABCD_1234, 16'h0065, Z);
    add(1'b0, 4'b0011, 4'b0011, 12'h0, 64'h0000_0000_ABCD_1234, 16'h0065,
        o(4'b0001, 4'b0001, 1'b1, 1'b0, 16'h1234, 4'h5, 4'h0, 4'h0, 1'b1));
    add(1'b0, 4'b0011, 4'b0011, 12'h0, 64'h0000_0000_ABCD_1234, 16'h0065, Z);
    add(1'b0, 4'b0011, 4'b0011, 12'h0, 64'h0000_0000_ABCD_1234, 16'h0065,
        o(4'b0010, 4'b0010, 1'b1, 1'b0, 16'hABCD, 4'h6, 4'h0, 4'h0, 1'b1));
    add(1'b0, 4'h0, 4'h0, 12'h0, 64'h0, 16'h0, Z);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].we, vecs[i].blen, vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("vec%0d", i), 64'(observed()), 64'(vecs[i].exp));
      if (i == 0) check("reset_raw_addr_rdata", 64'({bus.mem_addr, bus.rdata}), 64'h0);
      step();
    end

    // T2: all four request single-beat writes; grants rotate 0,1,2,3,0.
    exp_rr = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    do_reset();
    drive(1'b0, 4'hF, 4'hF, 12'h0, 64'h0004_0003_0002_0001, 16'h4321);
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("t2_rr_gnt%0d", c), 64'(bus.gnt), 64'(exp_rr[c]));
      step();
    end

    // T4: requester 0 8-beat write dropped after 3 beats; requester 3 waiting.
    do_reset();
    drive(1'b0, 4'b1001, 4'b1001, 12'h007, 64'h0200_0000_0000_0100, 16'h9007);
    #1;
    check("t4_idle_first", 64'(bus.gnt), 64'h0);
    step();
    for (int n = 0; n < 3; n++) begin
      #1;
      check($sformatf("t4_beat%0d", n), 64'({bus.ack, bus.mem_we, bus.mem_addr}),
            64'({4'b0001, 1'b1, 16'h0100 + 16'(n)}));
      step();
    end
    bus.req = 4'b1000;
    #1;
    check("t4_abort_cycle", 64'({bus.ack, bus.gnt, bus.mem_we, bus.mem_re}), 64'h0);
    step();
    #1;
    check("t4_idle_after", 64'({bus.busy, bus.gnt}), 64'h0);
    step();
    #1;
    check("t4_next_owner", 64'({bus.gnt, bus.mem_we, bus.mem_addr}),
          64'({4'b1000, 1'b1, 16'h0200}));
    step();

    // T6: requesters 0 and 1 both hold 8-beat write requests.
    do_reset();
    drive(1'b0, 4'b0011, 4'b0011, 12'h03F, 64'h0000_0000_2000_1000, 16'h0021);
    prev_ack = 4'h0;
    bad      = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.ack != 4'h0 && prev_ack == 4'h0) starts.push_back(bus.ack);
      if ($countones(bus.ack) > 1 || $countones(bus.gnt) > 1 ||
          (bus.mem_we && bus.mem_re)) bad++;
      prev_ack = bus.ack;
      step();
    end
    check("t6_burst_count_ge4", 64'(starts.size() >= 4), 64'h1);
    while (starts.size() < 4) starts.push_back(4'h0);
    check("t6_order", 64'({starts[0], starts[1], starts[2], starts[3]}), 64'h1212);
    for (int k = 1; k < starts.size(); k++) if (starts[k] == starts[k-1]) bad++;
    check("t6_no_repeat_onehot", 64'(bad), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
